seq_div: RTL and testbench

SEQ_DIV -- requirements
Module: seq_div

---
 rtl/alu_pkg.sv | 13 +
 rtl/div_step.sv | 24 ++
 rtl/seq_div.sv | 127 ++++++++++++
 tb/tb_seq_div.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared types and defaults for the arithmetic blocks.
// Holds the divider state encoding and the default operand width.
package alu_pkg;

  localparam int DIV_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } div_state_e;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift in the next dividend bit,
// trial-subtract the divisor magnitude and restore when the result goes negative.
import alu_pkg::*;

module div_step #(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic [WIDTH-1:0] rem,
  input  logic             next_bit,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] new_rem,
  output logic             q_bit
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] trial;

  // rem < divisor always holds, so the sign of a WIDTH+1 bit difference is exact.
  assign shifted = {rem, next_bit};
  assign trial   = shifted - {1'b0, divisor};
  assign q_bit   = ~trial[WIDTH];
  assign new_rem = q_bit ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];

endmodule

// File: rtl/seq_div.sv
// Sequential restoring divider, one quotient bit per cycle, signed or unsigned.
// Signs are stripped on accept and reapplied on the last iteration (truncating division).
import alu_pkg::*;

module seq_div #(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic             is_signed,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero,
  output div_state_e       state
);

  localparam int CW = $clog2(WIDTH) + 1;

  // Handshake: a transfer happens on a rising edge where valid and ready are both 1;
  // in_ready is high only in IDLE, out_valid only in DONE, and results hold until taken.
  div_state_e       state_q, state_d;
  logic [CW-1:0]    count_q;
  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] dvs_q;
  logic [WIDTH-1:0] rem_q;
  logic             dvd_neg_q;
  logic             quo_neg_q;

  logic             accept;
  logic             last;
  logic             dvd_neg;
  logic             dvs_neg;
  logic [WIDTH-1:0] dvd_abs;
  logic [WIDTH-1:0] dvs_abs;
  logic [WIDTH-1:0] rem_step;
  logic             q_bit;
  logic [WIDTH-1:0] q_mag;

  assign accept  = in_valid && in_ready;
  assign last    = (count_q == CW'(WIDTH - 1));
  assign dvd_neg = is_signed && dividend[WIDTH-1];
  assign dvs_neg = is_signed && divisor[WIDTH-1];
  assign dvd_abs = dvd_neg ? -dividend : dividend;
  assign dvs_abs = dvs_neg ? -divisor : divisor;
  assign q_mag   = {acc_q[WIDTH-2:0], q_bit};

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign state     = state_q;

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem      (rem_q),
    .next_bit (acc_q[WIDTH-1]),
    .divisor  (dvs_q),
    .new_rem  (rem_step),
    .q_bit    (q_bit)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = (divisor == '0) ? DONE : CALC;
      CALC:    if (last) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // acc_q starts as the dividend magnitude and fills with quotient bits from the LSB.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q     <= '0;
      acc_q       <= '0;
      dvs_q       <= '0;
      rem_q       <= '0;
      dvd_neg_q   <= 1'b0;
      quo_neg_q   <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            count_q   <= '0;
            acc_q     <= dvd_abs;
            dvs_q     <= dvs_abs;
            rem_q     <= '0;
            dvd_neg_q <= dvd_neg;
            quo_neg_q <= dvd_neg ^ dvs_neg;
            if (divisor == '0) begin
              quotient    <= '1;
              remainder   <= dividend;
              div_by_zero <= 1'b1;
            end
          end
        end
        CALC: begin
          acc_q   <= q_mag;
          rem_q   <= rem_step;
          count_q <= count_q + CW'(1);
          if (last) begin
            quotient    <= quo_neg_q ? -q_mag : q_mag;
            remainder   <= dvd_neg_q ? -rem_step : rem_step;
            div_by_zero <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_div.sv
// Directed bench for seq_div: driver issues requests and queues expected results,
// a monitor pops and compares at every output handshake.
import alu_pkg::*;

module tb_seq_div;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         is_signed;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;
  div_state_e   state;

  int checks   = 0;
  int failures = 0;
  logic [2*W:0] exp_q[$];

  always #5 clk = ~clk;

  seq_div #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .dividend    (dividend),
    .divisor     (divisor),
    .is_signed   (is_signed),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero),
    .state       (state)
  );

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: compares every delivered result against the head of the queue.
  initial begin
    logic [2*W:0] e;
    forever begin
      @(negedge clk);
      #1;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_result: got q=0x%0h r=0x%0h expected no result", quotient, remainder);
        end else begin
          e = exp_q.pop_front();
          check("quotient", quotient, e[2*W:W+1]);
          check("remainder", remainder, e[W:1]);
          check("div_by_zero", W'(div_by_zero), W'(e[0]));
        end
      end
    end
  end

  task automatic do_req(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                        input logic [W-1:0] eq, input logic [W-1:0] er, input logic ed,
                        input int lat, input bit hold);
    int k;
    bit seen;
    @(negedge clk);
    check("in_ready_idle", W'(in_ready), W'(1));
    in_valid  = 1'b1;
    dividend  = a;
    divisor   = b;
    is_signed = s;
    out_ready = !hold;
    exp_q.push_back({eq, er, ed});
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    seen = 1'b0;
    k = 1;
    while (!seen && k <= 100) begin
      if (out_valid) begin
        seen = 1'b1;
      end else begin
        in_valid  = 1'($urandom_range(0, 1));
        dividend  = $urandom;
        divisor   = $urandom;
        is_signed = 1'($urandom_range(0, 1));
        @(posedge clk);
        #1;
        k++;
      end
    end
    in_valid = 1'b0;
    if (!seen) begin
      checks++;
      failures++;
      $display("FAIL timeout: got no out_valid within 100 cycles expected latency %0d", lat);
      void'(exp_q.pop_back());
      out_ready = 1'b1;
      return;
    end
    check("latency", W'(k), W'(lat));
    if (hold) begin
      for (int i = 0; i < 5; i++) begin
        @(negedge clk);
        in_valid  = 1'b1;
        dividend  = $urandom;
        divisor   = $urandom;
        is_signed = 1'($urandom_range(0, 1));
        @(posedge clk);
        #1;
        check("hold_quotient", quotient, eq);
        check("hold_remainder", remainder, er);
        check("hold_in_ready", W'(in_ready), W'(0));
        check("hold_out_valid", W'(out_valid), W'(1));
      end
      @(negedge clk);
      in_valid  = 1'b0;
      out_ready = 1'b1;
    end
    @(posedge clk);
    #1;
    check("idle_after_handshake", W'(in_ready), W'(1));
  endtask

  initial begin
    bit ov_seen;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    dividend  = '0;
    divisor   = '0;
    is_signed = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset_state", W'(state), W'(IDLE));
    check("reset_quotient", quotient, '0);
    check("reset_remainder", remainder, '0);
    check("reset_dbz", W'(div_by_zero), W'(0));
    check("reset_out_valid", W'(out_valid), W'(0));
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("in_ready_after_reset", W'(in_ready), W'(1));

    do_req(32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 1'b0, 33, 1'b0);
    do_req(32'hFFFF_FFF9, 32'd2, 1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 33, 1'b0);
    do_req(32'd7, 32'hFFFF_FFFE, 1'b1, 32'hFFFF_FFFD, 32'd1, 1'b0, 33, 1'b0);
    do_req(32'd5, 32'd0, 1'b0, 32'hFFFF_FFFF, 32'd5, 1'b1, 1, 1'b0);
    do_req(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 32'd0, 1'b0, 33, 1'b0);
    do_req(32'hFFFF_FFFF, 32'd1, 1'b0, 32'hFFFF_FFFF, 32'd0, 1'b0, 33, 1'b0);
    do_req(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32'd0, 32'h8000_0000, 1'b0, 33, 1'b0);
    do_req(32'hFFFF_FF9C, 32'hFFFF_FFF9, 1'b1, 32'd14, 32'hFFFF_FFFE, 1'b0, 33, 1'b0);
    do_req(32'hFFFF_FFFB, 32'd0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFB, 1'b1, 1, 1'b0);
    do_req(32'd3, 32'd7, 1'b0, 32'd0, 32'd3, 1'b0, 33, 1'b0);
    do_req(32'hFFFF_FFFF, 32'h10, 1'b0, 32'h0FFF_FFFF, 32'hF, 1'b0, 33, 1'b0);
    do_req(32'd1000, 32'd10, 1'b0, 32'd100, 32'd0, 1'b0, 33, 1'b1);

    // Abort a division part-way through with a one-cycle reset.
    @(negedge clk);
    in_valid  = 1'b1;
    dividend  = 32'd1000;
    divisor   = 32'd3;
    is_signed = 1'b0;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("abort_state", W'(state), W'(IDLE));
    check("abort_quotient", quotient, '0);
    check("abort_remainder", remainder, '0);
    check("abort_dbz", W'(div_by_zero), W'(0));
    check("abort_out_valid", W'(out_valid), W'(0));
    @(negedge clk);
    rst_n = 1'b1;
    ov_seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (out_valid) ov_seen = 1'b1;
    end
    check("no_result_after_abort", W'(ov_seen), W'(0));
    do_req(32'd9, 32'd3, 1'b0, 32'd3, 32'd0, 1'b0, 33, 1'b0);

    repeat (3) @(posedge clk);
    #1;
    check("queue_drained", W'(exp_q.size()), W'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
